fold_misr_8bit: RTL and testbench

Downstream consumer of the 16-bit to 8-bit XOR fold stage. Accepts one folded pair (`aa`, `bb`) per handshake and compresses a fixed-length frame of pairs into two 8-bit MISR signatures. At frame end it presents both signatures and an equality flag through a valid/ready output port. It is used to compare the two folded channels over a whole frame, not word by word.

---
 rtl/fold_misr_8bit.sv | 105 ++++++++++
 tb/tb_fold_misr_8bit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fold_misr_8bit.sv
// Frame compressor for two folded 8-bit channels. Each accepted (aa, bb) pair steps two
// independent MISRs; after FrameLen pairs the signatures and their equality flag are held
// on a valid/ready output until the consumer takes them.
module fold_misr_8bit #(
  parameter int unsigned FrameLen = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] aa_i,
  input  logic [7:0] bb_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] sig_aa_o,
  output logic [7:0] sig_bb_o,
  output logic       eq_o,
  output logic [7:0] pair_cnt_o
);

  typedef enum logic [0:0] {StAccum, StHold} state_e;

  localparam logic [7:0] LastIdx = 8'(FrameLen - 1);

  state_e     state_q, state_d;
  logic [7:0] sig_aa_q, sig_aa_d;
  logic [7:0] sig_bb_q, sig_bb_d;
  logic [7:0] cnt_q, cnt_d;
  logic       eq_q, eq_d;

  // One MISR step for polynomial x^8+x^6+x^5+x^4+1, feedback entering at bit 0.
  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] d);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb} ^ d;
  endfunction

  // Next-state: clear wins over accept and over the output handshake.
  always_comb begin
    state_d  = state_q;
    sig_aa_d = sig_aa_q;
    sig_bb_d = sig_bb_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      state_d  = StAccum;
      sig_aa_d = 8'h00;
      sig_bb_d = 8'h00;
      cnt_d    = 8'h00;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (in_valid_i) begin
            sig_aa_d = misr_step(sig_aa_q, aa_i);
            sig_bb_d = misr_step(sig_bb_q, bb_i);
            if (cnt_q == LastIdx) begin
              cnt_d   = 8'h00;
              state_d = StHold;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        StHold: begin
          if (out_ready_i) begin
            sig_aa_d = 8'h00;
            sig_bb_d = 8'h00;
            state_d  = StAccum;
          end
        end
        default: state_d = StAccum;
      endcase
    end
    // Equality tracks the next MISR values so it stays aligned with the registers.
    eq_d = (sig_aa_d == sig_bb_d);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StAccum;
      sig_aa_q <= 8'h00;
      sig_bb_q <= 8'h00;
      cnt_q    <= 8'h00;
      eq_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      sig_aa_q <= sig_aa_d;
      sig_bb_q <= sig_bb_d;
      cnt_q    <= cnt_d;
      eq_q     <= eq_d;
    end
  end

  // Handshake outputs decode from registered state only.
  always_comb begin
    in_ready_o  = (state_q == StAccum);
    out_valid_o = (state_q == StHold);
    sig_aa_o    = sig_aa_q;
    sig_bb_o    = sig_bb_q;
    eq_o        = eq_q;
    pair_cnt_o  = cnt_q;
  end

endmodule

// File: tb/tb_fold_misr_8bit.sv
// Bench for fold_misr_8bit: a FrameLen=2 instance for hand-computed vectors and a
// FrameLen=16 instance for random frames checked against a queue-based reference model.
module tb_fold_misr_8bit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // FrameLen = 2 instance
  logic       clr2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b0;
  logic [7:0] aa2 = '0, bb2 = '0;
  logic       in_ready2, out_valid2, eq2;
  logic [7:0] sig_aa2, sig_bb2, cnt2;

  // FrameLen = 16 instance
  logic       clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] aa = '0, bb = '0;
  logic       in_ready, out_valid, eq;
  logic [7:0] sig_aa, sig_bb, cnt;

  fold_misr_8bit #(.FrameLen(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr2), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .aa_i(aa2), .bb_i(bb2), .out_valid_o(out_valid2), .out_ready_i(out_ready2),
    .sig_aa_o(sig_aa2), .sig_bb_o(sig_bb2), .eq_o(eq2), .pair_cnt_o(cnt2)
  );

  fold_misr_8bit #(.FrameLen(16)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .aa_i(aa), .bb_i(bb), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sig_aa_o(sig_aa), .sig_bb_o(sig_bb), .eq_o(eq), .pair_cnt_o(cnt)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: shift left by one (multiply by 2 mod 256), append the parity of taps 7,5,4,3,
  // then add the data word in GF(2).
  function automatic logic [7:0] ref_step(input logic [7:0] s, input logic [7:0] d);
    int v;
    int fb;
    fb = ((s >> 7) + (s >> 5) + (s >> 4) + (s >> 3)) % 2;
    v  = ((int'(s) * 2) % 256) + fb;
    return 8'(v) ^ d;
  endfunction

  function automatic logic [7:0] ref_sig(input logic [7:0] q[$]);
    logic [7:0] s;
    s = 8'h00;
    foreach (q[i]) s = ref_step(s, q[i]);
    return s;
  endfunction

  // Feeds one full FrameLen=16 frame (one accept per cycle) and returns the model signatures.
  task automatic run_frame(input bit same, output logic [7:0] ea, output logic [7:0] eb);
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    for (int i = 0; i < 16; i++) begin
      aa = 8'($urandom);
      bb = same ? aa : 8'($urandom);
      in_valid = 1'b1;
      qa.push_back(aa);
      qb.push_back(bb);
      chk("acc_in_ready", {31'd0, in_ready}, 32'd1);
      cyc();
      if (i < 15) chk("acc_pair_cnt", {24'd0, cnt}, i + 1);
    end
    ea = ref_sig(qa);
    eb = ref_sig(qb);
    chk("frame_out_valid", {31'd0, out_valid}, 32'd1);
    chk("frame_sig_aa", {24'd0, sig_aa}, {24'd0, ea});
    chk("frame_sig_bb", {24'd0, sig_bb}, {24'd0, eb});
    chk("frame_eq", {31'd0, eq}, {31'd0, ea == eb});
    chk("frame_cnt0", {24'd0, cnt}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] a0, b0, a1, b1;
    logic [7:0] sa, sb;
    logic       e;
  } vec_t;

  initial begin
    vec_t       vt[4];
    logic [7:0] ea, eb;

    vt[0] = '{a0: 8'h80, b0: 8'h00, a1: 8'h00, b1: 8'h00, sa: 8'h01, sb: 8'h00, e: 1'b0};
    vt[1] = '{a0: 8'h38, b0: 8'h38, a1: 8'h00, b1: 8'h00, sa: 8'h71, sb: 8'h71, e: 1'b1};
    vt[2] = '{a0: 8'h01, b0: 8'h01, a1: 8'h02, b1: 8'h02, sa: 8'h00, sb: 8'h00, e: 1'b1};
    vt[3] = '{a0: 8'hFF, b0: 8'h00, a1: 8'h00, b1: 8'hFF, sa: 8'hFE, sb: 8'hFF, e: 1'b0};

    // Reset values
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sig_aa", {24'd0, sig_aa}, 32'd0);
    chk("rst_sig_bb", {24'd0, sig_bb}, 32'd0);
    chk("rst_eq", {31'd0, eq}, 32'd1);
    chk("rst_cnt", {24'd0, cnt}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Table vectors on the FrameLen=2 instance
    for (int k = 0; k < 4; k++) begin
      in_valid2 = 1'b1;
      aa2 = vt[k].a0;
      bb2 = vt[k].b0;
      cyc();
      chk("t2_cnt1", {24'd0, cnt2}, 32'd1);
      chk("t2_mid_out_valid", {31'd0, out_valid2}, 32'd0);
      aa2 = vt[k].a1;
      bb2 = vt[k].b1;
      cyc();
      in_valid2 = 1'b0;
      chk("t2_out_valid", {31'd0, out_valid2}, 32'd1);
      chk("t2_in_ready", {31'd0, in_ready2}, 32'd0);
      chk("t2_sig_aa", {24'd0, sig_aa2}, {24'd0, vt[k].sa});
      chk("t2_sig_bb", {24'd0, sig_bb2}, {24'd0, vt[k].sb});
      chk("t2_eq", {31'd0, eq2}, {31'd0, vt[k].e});
      chk("t2_cnt0", {24'd0, cnt2}, 32'd0);
      out_ready2 = 1'b1;
      cyc();
      out_ready2 = 1'b0;
      chk("t2_drain_in_ready", {31'd0, in_ready2}, 32'd1);
      chk("t2_drain_sig_aa", {24'd0, sig_aa2}, 32'd0);
      chk("t2_drain_sig_bb", {24'd0, sig_bb2}, 32'd0);
    end

    // HOLD stall: in_valid stays high with fresh data that must be ignored
    run_frame(1'b0, ea, eb);
    for (int c = 0; c < 5; c++) begin
      aa = 8'($urandom);
      bb = 8'($urandom);
      cyc();
      chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_sig_aa", {24'd0, sig_aa}, {24'd0, ea});
      chk("stall_sig_bb", {24'd0, sig_bb}, {24'd0, eb});
      chk("stall_eq", {31'd0, eq}, {31'd0, ea == eb});
      chk("stall_cnt", {24'd0, cnt}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b0;
    chk("stall_rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk("stall_rel_out_valid", {31'd0, out_valid}, 32'd0);
    chk("stall_rel_sig_aa", {24'd0, sig_aa}, 32'd0);
    chk("stall_rel_sig_bb", {24'd0, sig_bb}, 32'd0);
    chk("stall_rel_eq", {31'd0, eq}, 32'd1);

    // Three back-to-back frames, out_ready tied high: 16 accepts + 1 hold cycle each
    out_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      run_frame(f == 1, ea, eb);
      aa = 8'($urandom);
      bb = 8'($urandom);
      cyc();
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      chk("b2b_out_valid", {31'd0, out_valid}, 32'd0);
      chk("b2b_sig_aa0", {24'd0, sig_aa}, 32'd0);
      chk("b2b_sig_bb0", {24'd0, sig_bb}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;

    // clr together with the 5th accept drops that pair
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      aa = 8'($urandom);
      bb = 8'($urandom);
      cyc();
    end
    chk("clr_pre_cnt", {24'd0, cnt}, 32'd4);
    aa = 8'($urandom) | 8'h01;
    bb = 8'($urandom);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_cnt", {24'd0, cnt}, 32'd0);
    chk("clr_sig_aa", {24'd0, sig_aa}, 32'd0);
    chk("clr_sig_bb", {24'd0, sig_bb}, 32'd0);
    chk("clr_eq", {31'd0, eq}, 32'd1);
    chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
    run_frame(1'b0, ea, eb);

    // clr while in HOLD beats a simultaneous output handshake
    in_valid = 1'b0;
    clr = 1'b1;
    out_ready = 1'b1;
    cyc();
    clr = 1'b0;
    out_ready = 1'b0;
    chk("clr_hold_out_valid", {31'd0, out_valid}, 32'd0);
    chk("clr_hold_sig_aa", {24'd0, sig_aa}, 32'd0);

    // Asynchronous reset between edges while in HOLD
    run_frame(1'b0, ea, eb);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_sig_aa", {24'd0, sig_aa}, 32'd0);
    chk("arst_sig_bb", {24'd0, sig_bb}, 32'd0);
    chk("arst_eq", {31'd0, eq}, 32'd1);
    chk("arst_cnt", {24'd0, cnt}, 32'd0);
    #2;
    rst_n = 1'b1;
    cyc();

    // A frame after the asynchronous reset starts from a zero seed
    run_frame(1'b0, ea, eb);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
